// File: rtl/program_counter_pkg.sv
// Shared datapath constants for the 16-bit core: PC width, instruction size, reset vector.
// Combinational helper only; no state, no latency, no flow control.
package program_counter_pkg;
   localparam int               PC_WIDTH     = 16;
   localparam int               INSTR_BYTES  = 2;
   localparam logic [15:0]      RESET_VECTOR = 16'h0000;

   // Registered result of one PC update: next address plus overflow indication.
   typedef struct packed {
      logic                     wrap;
      logic [PC_WIDTH-1:0]      pc;
   } pcUpdate_t;

   function automatic pcUpdate_t makePcUpdate(input logic [PC_WIDTH-1:0] pc, input logic wrap);
      pcUpdate_t u;
      u.pc   = pc;
      u.wrap = wrap;
      return u;
   endfunction
endpackage

// File: rtl/program_counter_pc_adder.sv
// Unsigned WIDTH-bit adder with carry-out; reusable for branch-target computation.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module program_counter_pc_adder #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carryOut
);
   assign {carryOut, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/program_counter.sv
// Registered PC update: newPC = oldPC + INC (mod 2^WIDTH), carry reported on pc_wrap.
// Latency: 1 cycle from oldPC sample to newPC; synchronous active-high reset wins.
// Backpressure: none; stalls are handled upstream by feeding back the held PC.
module program_counter
   import program_counter_pkg::*;
#(
   parameter int               WIDTH     = PC_WIDTH,
   parameter int               INC       = INSTR_BYTES,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VECTOR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] oldPC,
   output logic [WIDTH-1:0] newPC,
   output logic             pc_wrap
);
   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   logic [WIDTH-1:0] nextPc;
   logic             nextCarry;

   program_counter_pc_adder #(.WIDTH(WIDTH)) uAdder (
      .a        (oldPC),
      .b        (INC_W),
      .sum      (nextPc),
      .carryOut (nextCarry)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         newPC   <= RESET_VEC;
         pc_wrap <= 1'b0;
      end else begin
         newPC   <= nextPc;
         pc_wrap <= nextCarry;
      end
   end
endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: vector table plus hand sequences, scoreboarded.
module tb_program_counter;
   logic        clk = 1'b0;
   logic        resetA, resetB;
   logic [15:0] oldPcA, oldPcB;
   logic [15:0] newPcA, newPcB;
   logic        wrapA, wrapB;

   always #5 clk = ~clk;

   program_counter dutA (
      .clk(clk), .reset(resetA), .oldPC(oldPcA), .newPC(newPcA), .pc_wrap(wrapA)
   );

   program_counter #(.INC(1), .RESET_VEC(16'h0100)) dutB (
      .clk(clk), .reset(resetB), .oldPC(oldPcB), .newPC(newPcB), .pc_wrap(wrapB)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic [15:0] pc;
      logic [15:0] expPc;
      logic        expWrap;
   } vec_t;

   typedef struct {
      string       name;
      int          dut;
      logic [15:0] expPc;
      logic        expWrap;
   } exp_t;

   exp_t sb[$];
   int   checkCount = 0;
   int   passCount  = 0;

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checkCount++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else passCount++;
   endtask

   task automatic drive(input int dut, input vec_t v);
      exp_t e;
      @(negedge clk);
      if (dut == 0) begin resetA = v.rst; oldPcA = v.pc; end
      else          begin resetB = v.rst; oldPcB = v.pc; end
      e.name = v.name; e.dut = dut; e.expPc = v.expPc; e.expWrap = v.expWrap;
      sb.push_back(e);
   endtask

   task automatic collect();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checkCount++;
         $display("FAIL scoreboard: empty queue, got nothing, expected an entry");
         return;
      end
      e = sb.pop_front();
      if (e.dut == 0) begin
         check16({e.name, ".newPC"}, newPcA, e.expPc);
         check16({e.name, ".wrap"}, {15'd0, wrapA}, {15'd0, e.expWrap});
      end else begin
         check16({e.name, ".newPC"}, newPcB, e.expPc);
         check16({e.name, ".wrap"}, {15'd0, wrapB}, {15'd0, e.expWrap});
      end
   endtask

   task automatic apply(input int dut, input vec_t v);
      drive(dut, v);
      collect();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tabA[10];
      vec_t tabB[3];
      vec_t s;

      resetA = 1'b1; oldPcA = 16'h0000;
      resetB = 1'b1; oldPcB = 16'h0000;

      tabA[0] = '{"rstPrioFFFF", 1'b1, 16'hFFFF, 16'h0000, 1'b0};
      tabA[1] = '{"rstHoldA0A0", 1'b1, 16'hA0A0, 16'h0000, 1'b0};
      tabA[2] = '{"releaseA0A0", 1'b0, 16'hA0A0, 16'hA0A2, 1'b0};
      tabA[3] = '{"rstMidBBBB",  1'b1, 16'hBBBB, 16'h0000, 1'b0};
      tabA[4] = '{"wrapFFFF",    1'b0, 16'hFFFF, 16'h0001, 1'b1};
      tabA[5] = '{"after1234",   1'b0, 16'h1234, 16'h1236, 1'b0};
      tabA[6] = '{"wrapFFFE",    1'b0, 16'hFFFE, 16'h0000, 1'b1};
      tabA[7] = '{"zero",        1'b0, 16'h0000, 16'h0002, 1'b0};
      tabA[8] = '{"rstAgain",    1'b1, 16'h0000, 16'h0000, 1'b0};
      tabA[9] = '{"carry7FFF",   1'b0, 16'h7FFF, 16'h8001, 1'b0};

      for (int i = 0; i < 10; i++) apply(0, tabA[i]);

      // Mid-cycle glitch on oldPC: only the value at the edge may be used.
      s = '{"sampling", 1'b0, 16'h1000, 16'h1002, 1'b0};
      drive(0, s);
      #2 oldPcA = 16'h2000;
      #1 check16("holdMid.newPC", newPcA, 16'h8001);
      #1 oldPcA = 16'h1000;
      collect();
      #3 check16("holdAfter.newPC", newPcA, 16'h1002);

      tabB[0] = '{"B.reset",  1'b1, 16'h00FF, 16'h0100, 1'b0};
      tabB[1] = '{"B.inc00FF", 1'b0, 16'h00FF, 16'h0100, 1'b0};
      tabB[2] = '{"B.wrap",   1'b0, 16'hFFFF, 16'h0000, 1'b1};
      for (int i = 0; i < 3; i++) apply(1, tabB[i]);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
